// File: rtl/control_ascensor_if.sv
// Bundle between the request memory and the elevator controller.
// Optional: PARO_EMERGENCIA_EN adds the emergency-stop input paro.
interface control_ascensor_if;
   logic [3:0] memoria;
   logic [1:0] piso_m;
   logic [1:0] accion_m;
   logic       puertas_m;
   logic       consulta;
`ifdef PARO_EMERGENCIA_EN
   logic       paro;
`endif

   // Controller side
   modport master (
`ifdef PARO_EMERGENCIA_EN
      input  paro,
`endif
      input  memoria,
      output piso_m,
      output accion_m,
      output puertas_m,
      output consulta
   );

   // Memory / environment side
   modport slave (
`ifdef PARO_EMERGENCIA_EN
      output paro,
`endif
      output memoria,
      input  piso_m,
      input  accion_m,
      input  puertas_m,
      input  consulta
   );
endinterface

// File: rtl/control_ascensor.sv
// Elevator motion/door controller driven by the request memory's instruction code.
// Optional: PARO_EMERGENCIA_EN adds a synchronized emergency stop that freezes the controller.
module control_ascensor #(
   parameter int unsigned T_PISO   = 50,
   parameter int unsigned T_PUERTA = 25,
   parameter int unsigned T_SONDEO = 16
) (
   input logic                clk,
   input logic                rst,
   control_ascensor_if.master bus
);

   localparam int unsigned CNT_MAX =
      (T_PISO > T_PUERTA) ? ((T_PISO > T_SONDEO) ? T_PISO : T_SONDEO)
                          : ((T_PUERTA > T_SONDEO) ? T_PUERTA : T_SONDEO);
   localparam int unsigned CNT_W = $clog2(CNT_MAX);

   localparam logic [1:0] ACC_STOP = 2'd0;
   localparam logic [1:0] ACC_UP   = 2'd1;
   localparam logic [1:0] ACC_DOWN = 2'd2;

   typedef enum logic [2:0] {
      REPOSO   = 3'd0,
      CONSULTA = 3'd1,
      ESPERA   = 3'd2,
      SUBIENDO = 3'd3,
      BAJANDO  = 3'd4,
      PUERTA   = 3'd5
   } state_t;

   state_t             state_q, state_d, dec_state;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         piso_q, piso_d;
   logic [1:0]         dir_q, dir_d, dec_dir;
   logic [1:0]         accion_q, accion_d;
   logic               puertas_q, puertas_d;
   logic               consulta_q, consulta_d;
   logic               tgt_ok;
   logic [1:0]         tgt;
   logic               last_wait, last_travel, last_door, last_poll;
   logic               freeze, freeze_nx;

`ifdef PARO_EMERGENCIA_EN
   logic [1:0] paro_sync;

   // Two-flop synchronizer for the emergency stop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) paro_sync <= 2'b00;
      else      paro_sync <= {paro_sync[0], bus.paro};
   end

   assign freeze    = paro_sync[1];
   assign freeze_nx = paro_sync[0];
`else
   assign freeze    = 1'b0;
   assign freeze_nx = 1'b0;
`endif

   assign last_poll   = (cnt_q == CNT_W'(T_SONDEO - 1));
   assign last_wait   = (cnt_q == CNT_W'(1));
   assign last_travel = (cnt_q == CNT_W'(T_PISO - 1));
   assign last_door   = (cnt_q == CNT_W'(T_PUERTA - 1));

   // Decode the memory code into a target floor
   always_comb begin
      tgt_ok = 1'b1;
      tgt    = 2'd0;
      case (bus.memoria)
         4'd1, 4'd5:        tgt = 2'd0;
         4'd2, 4'd6, 4'd7:  tgt = 2'd1;
         4'd3, 4'd8, 4'd9:  tgt = 2'd2;
         4'd4, 4'd10:       tgt = 2'd3;
         default:           tgt_ok = 1'b0;
      endcase
   end

   // Decision taken at the end of the wait window
   always_comb begin
      dec_state = REPOSO;
      dec_dir   = ACC_STOP;
      if (!tgt_ok) begin
         dec_state = (dir_q == ACC_STOP) ? REPOSO : CONSULTA;
      end else if (tgt == piso_q) begin
         dec_state = PUERTA;
      end else if (tgt > piso_q) begin
         if (dir_q != ACC_DOWN) begin
            dec_state = SUBIENDO;
            dec_dir   = ACC_UP;
         end else begin
            dec_state = CONSULTA;
         end
      end else begin
         if (dir_q != ACC_UP) begin
            dec_state = BAJANDO;
            dec_dir   = ACC_DOWN;
         end else begin
            dec_state = CONSULTA;
         end
      end
   end

   // State and counter registers plus registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= REPOSO;
         cnt_q      <= '0;
         piso_q     <= 2'd0;
         dir_q      <= ACC_STOP;
         accion_q   <= ACC_STOP;
         puertas_q  <= 1'b0;
         consulta_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         piso_q     <= piso_d;
         dir_q      <= dir_d;
         accion_q   <= accion_d;
         puertas_q  <= puertas_d;
         consulta_q <= consulta_d;
      end
   end

   // Next state and shared cycle counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!freeze) begin
         case (state_q)
            REPOSO: begin
               if (last_poll) begin
                  state_d = CONSULTA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            CONSULTA: begin
               state_d = ESPERA;
               cnt_d   = '0;
            end
            ESPERA: begin
               if (last_wait) begin
                  state_d = dec_state;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SUBIENDO: begin
               if (last_travel) begin
                  state_d = (piso_q >= 2'd2) ? PUERTA : CONSULTA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            BAJANDO: begin
               if (last_travel) begin
                  state_d = (piso_q <= 2'd1) ? PUERTA : CONSULTA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PUERTA: begin
               if (last_door) begin
                  state_d = CONSULTA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = REPOSO;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Next values of floor, direction, doors and consult strobe
   always_comb begin
      piso_d    = piso_q;
      dir_d     = dir_q;
      puertas_d = puertas_q;
      if (!freeze) begin
         case (state_q)
            ESPERA: begin
               if (last_wait) begin
                  dir_d     = dec_dir;
                  puertas_d = (dec_state == PUERTA);
               end
            end
            SUBIENDO: begin
               if (last_travel) begin
                  if (piso_q <= 2'd2) piso_d = piso_q + 2'd1;
                  if (piso_q >= 2'd2) begin
                     dir_d     = ACC_STOP;
                     puertas_d = 1'b1;
                  end
               end
            end
            BAJANDO: begin
               if (last_travel) begin
                  if (piso_q >= 2'd1) piso_d = piso_q - 2'd1;
                  if (piso_q <= 2'd1) begin
                     dir_d     = ACC_STOP;
                     puertas_d = 1'b1;
                  end
               end
            end
            PUERTA: begin
               if (last_door) puertas_d = 1'b0;
            end
            default: ;
         endcase
      end
      accion_d   = freeze_nx ? ACC_STOP : dir_d;
      consulta_d = (state_d == CONSULTA) && !freeze_nx;
   end

   assign bus.piso_m    = piso_q;
   assign bus.accion_m  = accion_q;
   assign bus.puertas_m = puertas_q;
   assign bus.consulta  = consulta_q;

endmodule

// File: tb/tb_control_ascensor.sv
// Self-checking bench for control_ascensor: directed and random request sequences
// compared cycle by cycle against a segment-level model of the elevator.
module tb_control_ascensor;

   localparam int unsigned T_PISO   = 4;
   localparam int unsigned T_PUERTA = 3;
   localparam int unsigned T_SONDEO = 4;

   typedef struct {
      logic [5:0] out;   // {piso, accion, puertas, consulta}
      logic       smp;
      logic [3:0] mem;
   } exp_t;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   exp_t       exp_q[$];
   logic [3:0] dec_q[$];

   control_ascensor_if bus ();

   control_ascensor #(
      .T_PISO   (T_PISO),
      .T_PUERTA (T_PUERTA),
      .T_SONDEO (T_SONDEO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [5:0] pack(input int p, input int a, input bit d, input bit c);
      return {2'(p), 2'(a), d, c};
   endfunction

   // Floor targeted by a code, -1 when the code carries no request
   function automatic int decode(input logic [3:0] m);
      int v;
      v = int'(m);
      if (v >= 1 && v <= 4)  return v - 1;
      if (v >= 5 && v <= 10) return (v - 4) / 2;
      return -1;
   endfunction

   function automatic void emit(input int n, input int p, input int a, input bit d, input bit c);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.out = pack(p, a, d, c);
         e.smp = 1'b0;
         e.mem = 4'd0;
         exp_q.push_back(e);
      end
   endfunction

   // Expected output trace from reset release, one decision per entry of dec_q
   function automatic void build_model();
      int   piso, dir, tgt, want, k;
      exp_t e;
      exp_q.delete();
      piso = 0;
      dir  = 0;
      k    = 0;
      emit(T_SONDEO, 0, 0, 1'b0, 1'b0);
      while (k < dec_q.size()) begin
         emit(1, piso, dir, 1'b0, 1'b1);
         emit(1, piso, dir, 1'b0, 1'b0);
         e.out = pack(piso, dir, 1'b0, 1'b0);
         e.smp = 1'b1;
         e.mem = dec_q[k];
         exp_q.push_back(e);
         tgt = decode(dec_q[k]);
         k++;
         if (tgt < 0) begin
            if (dir == 0) emit(T_SONDEO, piso, 0, 1'b0, 1'b0);
            else          dir = 0;
         end else if (tgt == piso) begin
            dir = 0;
            emit(T_PUERTA, piso, 0, 1'b1, 1'b0);
         end else begin
            want = (tgt > piso) ? 1 : 2;
            if (dir != 0 && dir != want) begin
               dir = 0;
            end else begin
               dir = want;
               emit(T_PISO, piso, dir, 1'b0, 1'b0);
               piso = (dir == 1) ? piso + 1 : piso - 1;
               if ((dir == 1 && piso == 3) || (dir == 2 && piso == 0)) begin
                  dir = 0;
                  emit(T_PUERTA, piso, 0, 1'b1, 1'b0);
               end
            end
         end
      end
   endfunction

   // Reset pulse; returns at the negedge where reset is released (cycle 0)
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic logic [3:0] rand_code();
      int r;
      r = $urandom_range(9, 0);
      if (r < 6)      return 4'($urandom_range(10, 1));
      else if (r < 8) return 4'd0;
      else            return 4'($urandom_range(15, 11));
   endfunction

   task automatic test_reset();
      logic [5:0] act;
      rst = 1'b0;
      bus.memoria = 4'd0;
      repeat (3) @(negedge clk);
      act = {bus.piso_m, bus.accion_m, bus.puertas_m, bus.consulta};
      tests_run++;
      if (act !== 6'd0) begin
         tests_failed++;
         $display("FAIL reset_values: got %b expected %b", act, 6'd0);
      end
   endtask

   task automatic test_directed();
      logic [5:0] act;
      for (int s = 0; s < 5; s++) begin
         case (s)
            0: dec_q = '{4'd4, 4'd4, 4'd4, 4'd4};
            1: dec_q = '{4'd4, 4'd7, 4'd1, 4'd0};
            2: dec_q = '{4'd5, 4'd13, 4'd0};
            3: dec_q = '{4'd0, 4'd0, 4'd14};
            default: dec_q = '{4'd4, 4'd1, 4'd1, 4'd0};
         endcase
         build_model();
         do_reset();
         for (int i = 0; i < exp_q.size(); i++) begin
            bus.memoria = exp_q[i].smp ? exp_q[i].mem : 4'($urandom_range(15, 0));
            act = {bus.piso_m, bus.accion_m, bus.puertas_m, bus.consulta};
            tests_run++;
            if (act !== exp_q[i].out) begin
               tests_failed++;
               $display("FAIL directed s%0d cycle %0d: got %b expected %b (piso,accion,puertas,consulta)",
                        s, i, act, exp_q[i].out);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] act;
      for (int r = 0; r < 4; r++) begin
         dec_q.delete();
         for (int k = 0; k < 25; k++) dec_q.push_back(rand_code());
         build_model();
         do_reset();
         for (int i = 0; i < exp_q.size(); i++) begin
            bus.memoria = exp_q[i].smp ? exp_q[i].mem : 4'($urandom_range(15, 0));
            act = {bus.piso_m, bus.accion_m, bus.puertas_m, bus.consulta};
            tests_run++;
            if (act !== exp_q[i].out) begin
               tests_failed++;
               $display("FAIL random r%0d cycle %0d: got %b expected %b (piso,accion,puertas,consulta)",
                        r, i, act, exp_q[i].out);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_mid_travel();
      logic [5:0] act, want;
      int         idx;
      dec_q = '{4'd3, 4'd3};
      build_model();
      // second cycle of the F2->F3 leg: poll, consult, F1->F2 leg, consult, one travel cycle
      idx = T_SONDEO + 3 + T_PISO + 3 + 1;
      do_reset();
      for (int i = 0; i <= idx; i++) begin
         bus.memoria = exp_q[i].smp ? exp_q[i].mem : 4'($urandom_range(15, 0));
         act = {bus.piso_m, bus.accion_m, bus.puertas_m, bus.consulta};
         tests_run++;
         if (act !== exp_q[i].out) begin
            tests_failed++;
            $display("FAIL mid_travel_pre cycle %0d: got %b expected %b", i, act, exp_q[i].out);
         end
         if (i < idx) @(negedge clk);
      end
      tests_run++;
      if (act !== pack(1, 1, 1'b0, 1'b0)) begin
         tests_failed++;
         $display("FAIL mid_travel_moving: got %b expected %b", act, pack(1, 1, 1'b0, 1'b0));
      end
      #2 rst = 1'b0;
      #1;
      act = {bus.piso_m, bus.accion_m, bus.puertas_m, bus.consulta};
      tests_run++;
      if (act !== 6'd0) begin
         tests_failed++;
         $display("FAIL mid_travel_async_reset: got %b expected %b", act, 6'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.memoria = 4'd0;
      for (int i = 0; i < 2 * (T_SONDEO + 3); i++) begin
         want = pack(0, 0, 1'b0, (i % (T_SONDEO + 3)) == T_SONDEO);
         act  = {bus.piso_m, bus.accion_m, bus.puertas_m, bus.consulta};
         tests_run++;
         if (act !== want) begin
            tests_failed++;
            $display("FAIL post_reset_poll cycle %0d: got %b expected %b", i, act, want);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      bus.memoria  = 4'd0;
`ifdef PARO_EMERGENCIA_EN
      bus.paro     = 1'b0;
`endif
      test_reset();
      test_directed();
      test_random();
      test_reset_mid_travel();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
